// File: rtl/pmod_ssd_capture_pkg.sv
// Shared character table for the PmodSSD display path, plus the types and lookups
// used by both the encode and decode directions.
package pmod_ssd_capture_pkg;

  typedef logic [6:0] seg_pattern_t;  // {AA,AB,AC,AD,AE,AF,AG}
  typedef logic [4:0] char_code_t;

  typedef struct packed {
    logic       hit;
    char_code_t code;
  } char_lookup_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  localparam int NUM_CHARS = 32;

  // 0x1C ('S') and 0x1D ('O') alias 0x05 and 0x00; reverse lookup resolves them low.
  localparam seg_pattern_t CHAR_TABLE [NUM_CHARS] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
    7'b0110111, 7'b0001110, 7'b0010101, 7'b0011101,
    7'b1100111, 7'b0000101, 7'b0001111, 7'b0111110,
    7'b0111011, 7'b0000001, 7'b0001000, 7'b1000000,
    7'b1011011, 7'b1111110, 7'b0001101, 7'b0011100
  };

  function automatic seg_pattern_t char_to_seg(input char_code_t code);
    return CHAR_TABLE[code];
  endfunction

  // Scan from the top down so the lowest matching code is the one left standing.
  function automatic char_lookup_t seg_to_char(input seg_pattern_t pat);
    char_lookup_t r;
    r.hit  = 1'b0;
    r.code = '0;
    for (int i = NUM_CHARS - 1; i >= 0; i--) begin
      if (CHAR_TABLE[i] == pat) begin
        r.hit  = 1'b1;
        r.code = char_code_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ssd_sync_settle.sv
// Synchronizes the eight PmodSSD lines, detects digit-select edges and tracks how
// long the segment pattern has been steady since the last edge or change.
import pmod_ssd_capture_pkg::*;

module ssd_sync_settle #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  seg_pattern_t seg_raw,
  input  logic         c_raw,
  output seg_pattern_t seg_sync,
  output logic         c_sync,
  output logic         c_edge,
  output logic         settled
);

  localparam int SC_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_FIRE = SC_W'(SETTLE_CYCLES - 2);

  logic [7:0]      meta_q;
  logic [7:0]      sync_q;
  logic [7:0]      prev_q;
  logic [SC_W-1:0] stab_cnt;
  logic            stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      stab_cnt <= '0;
    end else begin
      meta_q <= {seg_raw, c_raw};
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (c_edge || !stable)
        stab_cnt <= '0;
      else if (stab_cnt != SC_MAX)
        stab_cnt <= stab_cnt + SC_W'(1);
    end
  end

  assign seg_sync = sync_q[7:1];
  assign c_sync   = sync_q[0];
  assign c_edge   = sync_q[0] ^ prev_q[0];
  assign stable   = (sync_q[7:1] == prev_q[7:1]);
  // High in the clk where stab_cnt is about to reach SETTLE_CYCLES-1, so the FSM
  // enters CAPTURE on the same edge the count completes.
  assign settled  = !c_edge && stable && (stab_cnt == SC_FIRE);

endmodule

// File: rtl/pmod_ssd_capture.sv
// PmodSSD receive front end: waits for segments to settle after each digit-select
// edge, decodes them through the shared table and tracks pair validity / staleness.
import pmod_ssd_capture_pkg::*;

module pmod_ssd_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CNT_W          = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SSD_AA,
  input  logic       SSD_AB,
  input  logic       SSD_AC,
  input  logic       SSD_AD,
  input  logic       SSD_AE,
  input  logic       SSD_AF,
  input  logic       SSD_AG,
  input  logic       SSD_C,
  output logic [4:0] digit0,
  output logic [4:0] digit1,
  output logic       digits_valid,
  output logic       decode_err,
  output logic       new_frame,
  output logic [1:0] fsm_state
);

  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  seg_pattern_t seg_sync;
  logic         c_sync;
  logic         c_edge;
  logic         settled;
  cap_state_e   state;
  cap_state_e   state_next;
  logic         capture;
  logic         slot_q;
  logic [1:0]   slot_seen;
  logic [CNT_W-1:0] to_cnt;
  logic         stale;
  logic         to_expire;
  logic         write_ok;
  char_lookup_t lookup;

  ssd_sync_settle #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .seg_raw ({SSD_AA, SSD_AB, SSD_AC, SSD_AD, SSD_AE, SSD_AF, SSD_AG}),
    .c_raw   (SSD_C),
    .seg_sync(seg_sync),
    .c_sync  (c_sync),
    .c_edge  (c_edge),
    .settled (settled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // An edge always wins: it restarts SETTLE even in the clk a settle would complete.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (c_edge) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (c_edge)       state_next = ST_SETTLE;
        else if (settled) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = c_edge ? ST_SETTLE : ST_DONE;
      end
      ST_DONE: begin
        if (c_edge) state_next = ST_SETTLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign lookup     = seg_to_char(seg_sync);
  assign write_ok   = capture && lookup.hit;
  assign decode_err = capture && !lookup.hit;
  assign new_frame  = write_ok && slot_q && slot_seen[0];

  // slot_q only moves on an edge, so a capture coinciding with an edge uses the old slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= 1'b0;
      digit0 <= 5'h00;
      digit1 <= 5'h00;
    end else begin
      if (c_edge) slot_q <= c_sync;
      if (write_ok) begin
        if (slot_q) digit1 <= lookup.code;
        else        digit0 <= lookup.code;
      end
    end
  end

  assign to_expire = !c_edge && (to_cnt == TO_MAX - CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt    <= '0;
      stale     <= 1'b0;
      slot_seen <= 2'b00;
    end else begin
      if (c_edge) begin
        to_cnt <= '0;
        stale  <= 1'b0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + CNT_W'(1);
        if (to_expire) stale <= 1'b1;
      end
      if (to_expire)     slot_seen         <= 2'b00;
      else if (write_ok) slot_seen[slot_q] <= 1'b1;
    end
  end

  assign digits_valid = slot_seen[0] && slot_seen[1] && !stale;
  assign fsm_state    = state;

endmodule

// File: tb/tb_pmod_ssd_capture.sv
// Directed and randomized checks of pmod_ssd_capture against a table-driven reference.
module tb_pmod_ssd_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg = 7'h00;
  logic       ssd_c = 1'b0;
  logic [4:0] digit0, digit1;
  logic       digits_valid, decode_err, new_frame;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int nf_cnt = 0, de_cnt = 0, nf_exp = 0, de_exp = 0;

  logic [4:0] m_dig [2];
  logic       m_seen [2];

  logic [6:0] ref_tab [32] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
    7'b0110111, 7'b0001110, 7'b0010101, 7'b0011101,
    7'b1100111, 7'b0000101, 7'b0001111, 7'b0111110,
    7'b0111011, 7'b0000001, 7'b0001000, 7'b1000000,
    7'b1011011, 7'b1111110, 7'b0001101, 7'b0011100
  };

  pmod_ssd_capture #(
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(200),
    .CNT_W(21)
  ) dut (
    .clk(clk), .reset(reset),
    .SSD_AA(seg[6]), .SSD_AB(seg[5]), .SSD_AC(seg[4]), .SSD_AD(seg[3]),
    .SSD_AE(seg[2]), .SSD_AF(seg[1]), .SSD_AG(seg[0]), .SSD_C(ssd_c),
    .digit0(digit0), .digit1(digit1), .digits_valid(digits_valid),
    .decode_err(decode_err), .new_frame(new_frame), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (new_frame === 1'b1)  nf_cnt++;
      if (decode_err === 1'b1) de_cnt++;
    end
  end

  // Lowest code whose pattern matches wins; bit 5 = hit.
  function automatic logic [5:0] ref_lookup(input logic [6:0] pat);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 0; i < 32; i++)
      if (!r[5] && ref_tab[i] == pat) r = {1'b1, 5'(i)};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_digit0"}, 32'(digit0), 32'(m_dig[0]));
    check({tag, "_digit1"}, 32'(digit1), 32'(m_dig[1]));
    check({tag, "_valid"}, 32'(digits_valid), 32'(m_seen[0] & m_seen[1]));
  endtask

  // Present a new slot/pattern at a negedge and follow it through capture.
  task automatic step(input logic c, input logic [6:0] pat, input int hold);
    logic [5:0] lk;
    logic       exp_nf;
    lk = ref_lookup(pat);
    exp_nf = lk[5] & c & m_seen[0];
    @(negedge clk);
    ssd_c = c;
    seg   = pat;
    repeat (6) @(posedge clk);
    #1;
    check("pre_capture_digit", 32'(c ? digit1 : digit0), 32'(m_dig[c]));
    check("new_frame_pulse", 32'(new_frame), 32'(exp_nf));
    check("decode_err_pulse", 32'(decode_err), 32'(!lk[5]));
    @(posedge clk);
    #1;
    if (lk[5]) begin
      m_dig[c]  = lk[4:0];
      m_seen[c] = 1'b1;
    end
    nf_exp += int'(exp_nf);
    de_exp += int'(!lk[5]);
    check("post_capture_digit", 32'(c ? digit1 : digit0), 32'(m_dig[c]));
    repeat (hold - 7) @(posedge clk);
    #1;
    check_outputs("hold");
  endtask

  initial begin
    logic [5:0] lk;
    logic       rc;
    logic [6:0] rp;
    m_dig[0] = 5'h00; m_dig[1] = 5'h00;
    m_seen[0] = 1'b0; m_seen[1] = 1'b0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_digit0", 32'(digit0), 32'h0);
    check("reset_digit1", 32'(digit1), 32'h0);
    check("reset_valid", 32'(digits_valid), 32'h0);
    check("reset_decode_err", 32'(decode_err), 32'h0);
    check("reset_new_frame", 32'(new_frame), 32'h0);
    check("reset_state", 32'(fsm_state), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset asserted mid-SETTLE
    step(1'b1, ref_tab[5'h11], 20);
    @(negedge clk);
    ssd_c = 1'b0;
    seg   = ref_tab[5'h03];
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_digit1", 32'(digit1), 32'h0);
    check("midreset_valid", 32'(digits_valid), 32'h0);
    check("midreset_state", 32'(fsm_state), 32'h0);
    m_dig[0] = 5'h00; m_dig[1] = 5'h00;
    m_seen[0] = 1'b0; m_seen[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_outputs("post_reset");
    check("post_reset_state", 32'(fsm_state), 32'h0);

    // Basic pair capture with latency and new_frame
    step(1'b1, ref_tab[5'h11], 50);
    step(1'b0, ref_tab[5'h03], 50);
    step(1'b1, ref_tab[5'h0A], 50);

    // Shared pattern resolves to the lowest code
    step(1'b0, ref_tab[5'h1C], 20);
    check("alias_code", 32'(digit0), 32'h05);
    step(1'b1, ref_tab[5'h0A], 20);

    // Segment chatter after an edge delays capture until the final pattern settles
    @(negedge clk);
    ssd_c = 1'b0;
    seg   = 7'b1111111;
    for (int i = 0; i < 9; i++) begin
      repeat (2) @(negedge clk);
      seg[0] = ~seg[0];
    end
    lk = ref_lookup(seg);
    repeat (6) @(posedge clk);
    #1;
    check("chatter_pre_capture", 32'(digit0), 32'(m_dig[0]));
    @(posedge clk);
    #1;
    m_dig[0] = lk[4:0];
    check("chatter_capture", 32'(digit0), 32'h00);
    repeat (10) @(posedge clk);
    #1;
    check_outputs("chatter_hold");

    // Unknown pattern on slot 1
    step(1'b1, 7'b0000000, 20);

    // Timeout after a valid pair, then recovery
    step(1'b0, ref_tab[5'h03], 20);
    step(1'b1, ref_tab[5'h0A], 8);
    repeat (182) @(posedge clk);
    #1;
    check("timeout_before", 32'(digits_valid), 32'h1);
    repeat (15) @(posedge clk);
    #1;
    check("timeout_after", 32'(digits_valid), 32'h0);
    check("timeout_digit0", 32'(digit0), 32'h03);
    check("timeout_digit1", 32'(digit1), 32'h0A);
    m_seen[0] = 1'b0; m_seen[1] = 1'b0;
    step(1'b0, ref_tab[5'h03], 20);
    step(1'b1, ref_tab[5'h0A], 20);

    // Second edge 3 clks after the first abandons the first slot
    @(negedge clk);
    ssd_c = 1'b0;
    seg   = ref_tab[5'h07];
    repeat (2) @(negedge clk);
    step(1'b1, ref_tab[5'h09], 20);

    // Randomized slots and patterns
    rc = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rc = ~rc;
      if ($urandom_range(0, 9) == 0) rp = 7'($urandom_range(0, 127));
      else                           rp = ref_tab[$urandom_range(0, 31)];
      step(rc, rp, int'($urandom_range(8, 30)));
    end

    repeat (4) @(posedge clk);
    #1;
    check("new_frame_count", 32'(nf_cnt), 32'(nf_exp));
    check("decode_err_count", 32'(de_cnt), 32'(de_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
